// File: rtl/vram_wr_sched.sv
// VRAM write scheduler: arbitrates a small CPU write FIFO against a full-screen fill engine.
// Define VRAM_WR_VBLANK_ONLY_EN to restrict every VRAM write to blanking slots.
module vram_wr_sched #(
    parameter int C_AW        = 10,
    parameter int C_DW        = 8,
    parameter int C_FIFO_LOG2 = 2,
    parameter int C_FAIR_N    = 4
) (
    input  logic            CK_i,
    input  logic            SR_i,
    input  logic            CK_EE_i,
    input  logic            XVD_i,
    input  logic            BLANK_i,
    input  logic [C_DW-1:0] CPU_WDs_i,
    input  logic [C_AW-1:0] CPU_WAs_i,
    input  logic            CPU_WE_i,
    output logic            CPU_FULL_o,
    output logic            CPU_OVF_o,
    input  logic            FILL_START_i,
    input  logic            FILL_MODE_i,
    input  logic [C_DW-1:0] FILL_DATAs_i,
    output logic            FILL_BUSY_o,
    output logic            FILL_DONE_o,
    output logic [C_DW-1:0] VRAM_WDs_o,
    output logic [C_AW-1:0] VRAM_WAs_o,
    output logic            VRAM_WE_o
);
    // state   | meaning
    // IDLE    | no fill pending, waits for FILL_START_i
    // WAIT_VD | fill armed, waits for a CK_EE_i slot with XVD_i=0
    // RUN     | fill competes for write slots, address advancing
    // DONE    | last fill write issued, one cycle before IDLE
    typedef enum logic [1:0] {S_IDLE, S_WAIT_VD, S_RUN, S_DONE} state_t;

    localparam int DEPTH = 1 << C_FIFO_LOG2;
    localparam int FCW   = $clog2(C_FAIR_N + 1);

    state_t                 state_q, state_d;
    logic [C_AW-1:0]        fill_addr_q, fill_addr_d;
    logic                   fill_mode_q, fill_mode_d;
    logic [C_DW-1:0]        fill_seed_q, fill_seed_d;
    logic [FCW-1:0]         fair_q, fair_d;
    logic [C_AW+C_DW-1:0]   mem_q [DEPTH];
    logic [C_FIFO_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [C_FIFO_LOG2:0]   count_q, count_d;
    logic                   full_q, ovf_q;
    logic                   we_q, done_q;
    logic [C_AW-1:0]        wa_q;
    logic [C_DW-1:0]        wd_q;
    logic                   push, pop, cpu_req, fill_run, force_fill, slot;
    logic                   gnt_cpu, gnt_fill;
    logic [C_DW-1:0]        fill_data;

`ifdef VRAM_WR_VBLANK_ONLY_EN
    assign slot = CK_EE_i & BLANK_i;
`else
    logic unused_blank;
    assign unused_blank = BLANK_i;
    assign slot         = CK_EE_i;
`endif

    assign push       = CPU_WE_i & ~full_q;
    assign cpu_req    = (count_q != '0);
    assign fill_run   = (state_q == S_RUN);
    assign force_fill = fill_run & (fair_q == FCW'(C_FAIR_N));
    assign gnt_cpu    = slot & cpu_req & ~force_fill;
    assign gnt_fill   = slot & fill_run & (~cpu_req | force_fill);
    assign pop        = gnt_cpu;
    assign fill_data  = fill_mode_q ? fill_seed_q + C_DW'(fill_addr_q) : fill_seed_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // The fairness run length only matters while the fill is actually competing.
    always_comb begin
        fair_d = fair_q;
        if (!fill_run || gnt_fill) begin
            fair_d = '0;
        end else if (gnt_cpu && !force_fill) begin
            fair_d = fair_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_addr_d = fill_addr_q;
        fill_mode_d = fill_mode_q;
        fill_seed_d = fill_seed_q;
        case (state_q)
            S_IDLE: begin
                if (FILL_START_i) begin
                    fill_mode_d = FILL_MODE_i;
                    fill_seed_d = FILL_DATAs_i;
                    fill_addr_d = '0;
                    state_d     = S_WAIT_VD;
                end
            end
            S_WAIT_VD: begin
                if (CK_EE_i && !XVD_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (gnt_fill) begin
                    fill_addr_d = fill_addr_q + 1'b1;
                    if (fill_addr_q == '1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CK_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {CPU_WAs_i, CPU_WDs_i};
        end
    end

    always_ff @(posedge CK_i) begin
        if (SR_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            state_q     <= S_IDLE;
            fill_addr_q <= '0;
            fill_mode_q <= 1'b0;
            fill_seed_q <= '0;
            fair_q      <= '0;
            we_q        <= 1'b0;
            wa_q        <= '0;
            wd_q        <= '0;
            done_q      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q     <= count_d;
            full_q      <= (count_d == (C_FIFO_LOG2 + 1)'(DEPTH));
            if (CPU_WE_i && full_q) begin
                ovf_q <= 1'b1;
            end
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
            fill_mode_q <= fill_mode_d;
            fill_seed_q <= fill_seed_d;
            fair_q      <= fair_d;
            we_q        <= gnt_cpu | gnt_fill;
            if (gnt_cpu) begin
                {wa_q, wd_q} <= mem_q[rd_ptr_q];
            end else if (gnt_fill) begin
                wa_q <= fill_addr_q;
                wd_q <= fill_data;
            end
            done_q      <= (state_q == S_DONE);
        end
    end

    assign CPU_FULL_o  = full_q;
    assign CPU_OVF_o   = ovf_q;
    assign FILL_BUSY_o = (state_q != S_IDLE);
    assign FILL_DONE_o = done_q;
    assign VRAM_WE_o   = we_q;
    assign VRAM_WAs_o  = wa_q;
    assign VRAM_WDs_o  = wd_q;
endmodule

// File: tb/tb_vram_wr_sched.sv
// Scoreboard bench for vram_wr_sched: expected writes are queued by the stimulus, popped by a monitor.
// Honours VRAM_WR_VBLANK_ONLY_EN the same way the design does.
module tb_vram_wr_sched;
    localparam int AW = 10;
    localparam int DW = 8;

    logic          CK_i = 1'b0;
    logic          SR_i = 1'b1;
    logic          CK_EE_i = 1'b0;
    logic          XVD_i = 1'b1;
    logic          BLANK_i = 1'b1;
    logic [DW-1:0] CPU_WDs_i = '0;
    logic [AW-1:0] CPU_WAs_i = '0;
    logic          CPU_WE_i = 1'b0;
    logic          CPU_FULL_o, CPU_OVF_o;
    logic          FILL_START_i = 1'b0;
    logic          FILL_MODE_i = 1'b0;
    logic [DW-1:0] FILL_DATAs_i = '0;
    logic          FILL_BUSY_o, FILL_DONE_o;
    logic [DW-1:0] VRAM_WDs_o;
    logic [AW-1:0] VRAM_WAs_o;
    logic          VRAM_WE_o;

    vram_wr_sched dut (
        .CK_i(CK_i), .SR_i(SR_i), .CK_EE_i(CK_EE_i), .XVD_i(XVD_i), .BLANK_i(BLANK_i),
        .CPU_WDs_i(CPU_WDs_i), .CPU_WAs_i(CPU_WAs_i), .CPU_WE_i(CPU_WE_i),
        .CPU_FULL_o(CPU_FULL_o), .CPU_OVF_o(CPU_OVF_o),
        .FILL_START_i(FILL_START_i), .FILL_MODE_i(FILL_MODE_i), .FILL_DATAs_i(FILL_DATAs_i),
        .FILL_BUSY_o(FILL_BUSY_o), .FILL_DONE_o(FILL_DONE_o),
        .VRAM_WDs_o(VRAM_WDs_o), .VRAM_WAs_o(VRAM_WAs_o), .VRAM_WE_o(VRAM_WE_o)
    );

    always #5 CK_i = ~CK_i;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           cpu_q[$];
    wr_t           fill_q[$];
    wr_t           mon_e;
    bit            src_log[$];
    int            tests = 0;
    int            fails = 0;
    int            edge_n = 0;
    int            wr_cnt = 0;
    int            last_we_edge = -1;
    int            done_cnt = 0;
    int            done_edge = -1;
    bit            log_en = 1'b0;
    bit            fmode1 = 1'b0;
    bit            f0_seen = 1'b0;
    logic [DW-1:0] d_at_f0 = '1;
    bit            ee_run = 1'b0;
    int            ee_ph = 0;

    always @(posedge CK_i) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every VRAM write must be the next fill write or the next CPU write.
    always @(negedge CK_i) begin
        if (SR_i === 1'b0) begin
            if (FILL_DONE_o === 1'b1) begin
                done_cnt++;
                done_edge = edge_n;
            end
            if (VRAM_WE_o === 1'b1) begin
                wr_cnt++;
                last_we_edge = edge_n;
                if (fmode1 && VRAM_WAs_o == 10'h0F0) begin
                    d_at_f0 = VRAM_WDs_o;
                    f0_seen = 1'b1;
                end
                if (fill_q.size() > 0 && fill_q[0].a == VRAM_WAs_o && fill_q[0].d == VRAM_WDs_o) begin
                    void'(fill_q.pop_front());
                    tests++;
                    if (log_en) src_log.push_back(1'b1);
                end else if (cpu_q.size() > 0) begin
                    mon_e = cpu_q.pop_front();
                    chk("cpu_write", 32'({VRAM_WAs_o, VRAM_WDs_o}), 32'({mon_e.a, mon_e.d}));
                    if (log_en) src_log.push_back(1'b0);
                end else begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                             VRAM_WAs_o, VRAM_WDs_o);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CK_i);
        #1;
        if (ee_run) begin
            ee_ph   = (ee_ph == 2) ? 0 : ee_ph + 1;
            CK_EE_i = (ee_ph == 0);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_we"}, 32'(VRAM_WE_o), 32'd0);
        chk({tag, "_wa"}, 32'(VRAM_WAs_o), 32'd0);
        chk({tag, "_wd"}, 32'(VRAM_WDs_o), 32'd0);
        chk({tag, "_full"}, 32'(CPU_FULL_o), 32'd0);
        chk({tag, "_ovf"}, 32'(CPU_OVF_o), 32'd0);
        chk({tag, "_busy"}, 32'(FILL_BUSY_o), 32'd0);
        chk({tag, "_done"}, 32'(FILL_DONE_o), 32'd0);
    endtask

    task automatic wait_fill_idle(input string tag, input int limit);
        int n = 0;
        while (FILL_BUSY_o && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got busy after %0d cycles expected idle", tag, n);
        end
    endtask

    initial begin
        int  w0, e, dc0, sent, f0, n;
        logic [AW-1:0] av;
        logic [4:0]    pat;

        // ---- reset state
        ticks(3);
        SR_i = 1'b0;
        tick();
        chk_outputs_zero("reset");

        // ---- CPU latency: push at edge E, CK_EE at E+1, write visible after E+1
        w0 = wr_cnt;
        CPU_WAs_i = 10'h155; CPU_WDs_i = 8'hA5; CPU_WE_i = 1'b1;
        cpu_q.push_back('{a: 10'h155, d: 8'hA5});
        tick();
        e = edge_n;
        CPU_WE_i = 1'b0; CK_EE_i = 1'b1;
        tick();
        CK_EE_i = 1'b0;
        ticks(3);
        chk("lat_count", 32'(wr_cnt - w0), 32'd1);
        chk("lat_edge", 32'(last_we_edge), 32'(e + 1));

        // ---- overflow: 6 pushes, no write slots
        w0 = wr_cnt;
        for (int i = 0; i < 6; i++) begin
            CPU_WAs_i = AW'(i + 1); CPU_WDs_i = DW'(8'h11 + i); CPU_WE_i = 1'b1;
            if (i < 4) cpu_q.push_back('{a: AW'(i + 1), d: DW'(8'h11 + i)});
            tick();
        end
        CPU_WE_i = 1'b0;
        chk("ovf_full", 32'(CPU_FULL_o), 32'd1);
        chk("ovf_flag", 32'(CPU_OVF_o), 32'd1);
        chk("ovf_nowrite", 32'(wr_cnt - w0), 32'd0);
        ee_run = 1'b1;
        ticks(30);
        ee_run = 1'b0; CK_EE_i = 1'b0;
        chk("ovf_drain_count", 32'(wr_cnt - w0), 32'd4);
        chk("ovf_queue_left", 32'(cpu_q.size()), 32'd0);
        chk("ovf_full_after", 32'(CPU_FULL_o), 32'd0);
        chk("ovf_sticky", 32'(CPU_OVF_o), 32'd1);

        // ---- fill mode 1, seed 0x10, held off by XVD_i
        for (int a = 0; a < 1024; a++) begin
            av = AW'(a);
            fill_q.push_back('{a: av, d: 8'h10 + av[7:0]});
        end
        w0 = wr_cnt; dc0 = done_cnt; fmode1 = 1'b1;
        XVD_i = 1'b1; FILL_MODE_i = 1'b1; FILL_DATAs_i = 8'h10; FILL_START_i = 1'b1;
        ee_run = 1'b1;
        tick();
        FILL_START_i = 1'b0; FILL_DATAs_i = 8'h77; FILL_MODE_i = 1'b0;
        ticks(30);
        chk("fill1_waiting_busy", 32'(FILL_BUSY_o), 32'd1);
        chk("fill1_waiting_nowrite", 32'(wr_cnt - w0), 32'd0);
        XVD_i = 1'b0;
        wait_fill_idle("fill1", 5000);
        XVD_i = 1'b1;
        ticks(5);
        fmode1 = 1'b0;
        chk("fill1_count", 32'(wr_cnt - w0), 32'd1024);
        chk("fill1_left", 32'(fill_q.size()), 32'd0);
        chk("fill1_done_pulses", 32'(done_cnt - dc0), 32'd1);
        chk("fill1_done_edge", 32'(done_edge), 32'(last_we_edge + 1));
        chk("fill1_f0_seen", 32'(f0_seen), 32'd1);
        chk("fill1_data_0f0", 32'(d_at_f0), 32'h00);

        // ---- fairness: constant 0 fill against a continuously full CPU FIFO
        for (int a = 0; a < 1024; a++) fill_q.push_back('{a: AW'(a), d: 8'h00});
        w0 = wr_cnt; dc0 = done_cnt; sent = 0; n = 0;
        src_log.delete();
        log_en = 1'b1;
        XVD_i = 1'b0; FILL_MODE_i = 1'b0; FILL_DATAs_i = 8'h00; FILL_START_i = 1'b1;
        while (!(sent >= 200 && !FILL_BUSY_o && cpu_q.size() == 0) && n < 8000) begin
            CPU_WE_i = 1'b0;
            if (!CPU_FULL_o && sent < 200) begin
                CPU_WAs_i = AW'((sent * 7) % 1024);
                CPU_WDs_i = DW'(8'h80 | (sent % 128));
                CPU_WE_i  = 1'b1;
                cpu_q.push_back('{a: AW'((sent * 7) % 1024), d: DW'(8'h80 | (sent % 128))});
                sent++;
            end
            if (n == 100) begin
                FILL_START_i = 1'b1; FILL_MODE_i = 1'b1; FILL_DATAs_i = 8'h55;
            end
            tick();
            FILL_START_i = 1'b0;
            n++;
        end
        CPU_WE_i = 1'b0;
        if (n >= 8000) begin
            tests++;
            fails++;
            $display("FAIL fair_timeout: got busy after %0d cycles expected idle", n);
        end
        ticks(5);
        log_en = 1'b0;
        f0 = -1;
        for (int i = 0; i < src_log.size(); i++) begin
            if (src_log[i] && f0 < 0) f0 = i;
        end
        chk("fair_first_fill_pos", 32'(f0), 32'd5);
        for (int g = 0; g < 25; g++) begin
            pat = '1;
            if (f0 >= 0 && f0 + 5 * g + 5 < src_log.size()) begin
                for (int k = 1; k <= 5; k++) pat[5 - k] = src_log[f0 + 5 * g + k];
            end
            chk("fair_group", 32'(pat), 32'b00001);
        end
        chk("fair_cpu_left", 32'(cpu_q.size()), 32'd0);
        chk("fair_fill_left", 32'(fill_q.size()), 32'd0);
        chk("fair_total", 32'(wr_cnt - w0), 32'd1224);
        chk("fair_done_pulses", 32'(done_cnt - dc0), 32'd1);

        // ---- blanking-gated writes
        ee_run = 1'b0; CK_EE_i = 1'b0; XVD_i = 1'b1;
`ifdef VRAM_WR_VBLANK_ONLY_EN
        BLANK_i = 1'b0;
        CPU_WAs_i = 10'h3AA; CPU_WDs_i = 8'h5C; CPU_WE_i = 1'b1;
        cpu_q.push_back('{a: 10'h3AA, d: 8'h5C});
        tick();
        CPU_WAs_i = 10'h3AB; CPU_WDs_i = 8'h5D;
        cpu_q.push_back('{a: 10'h3AB, d: 8'h5D});
        tick();
        CPU_WE_i = 1'b0;
        w0 = wr_cnt;
        ee_run = 1'b1;
        ticks(300);
        ee_run = 1'b0; CK_EE_i = 1'b0;
        tick();
        chk("blank_held", 32'(wr_cnt - w0), 32'd0);
        BLANK_i = 1'b1; CK_EE_i = 1'b1;
        tick();
        e = edge_n;
        CK_EE_i = 1'b0;
        ticks(2);
        chk("blank_resume_count", 32'(wr_cnt - w0), 32'd1);
        chk("blank_resume_edge", 32'(last_we_edge), 32'(e));
        ee_run = 1'b1;
        ticks(10);
        ee_run = 1'b0; CK_EE_i = 1'b0;
        chk("blank_drain", 32'(wr_cnt - w0), 32'd2);
`else
        BLANK_i = 1'b0;
        w0 = wr_cnt;
        CPU_WAs_i = 10'h3AA; CPU_WDs_i = 8'h5C; CPU_WE_i = 1'b1;
        cpu_q.push_back('{a: 10'h3AA, d: 8'h5C});
        tick();
        CPU_WE_i = 1'b0;
        ee_run = 1'b1;
        ticks(10);
        ee_run = 1'b0; CK_EE_i = 1'b0;
        chk("blank_ignored", 32'(wr_cnt - w0), 32'd1);
        BLANK_i = 1'b1;
`endif

        // ---- reset mid-fill with 3 FIFO entries pending
        for (int a = 0; a < 1024; a++) fill_q.push_back('{a: AW'(a), d: 8'h3C});
        w0 = wr_cnt;
        XVD_i = 1'b0; FILL_MODE_i = 1'b0; FILL_DATAs_i = 8'h3C; FILL_START_i = 1'b1;
        ee_run = 1'b1;
        tick();
        FILL_START_i = 1'b0;
        ticks(60);
        ee_run = 1'b0; CK_EE_i = 1'b0;
        ticks(2);
        chk("rst_prefill_some", 32'(wr_cnt - w0 > 0), 32'd1);
        for (int i = 0; i < 3; i++) begin
            CPU_WAs_i = AW'(10'h200 + i); CPU_WDs_i = DW'(8'hC0 + i); CPU_WE_i = 1'b1;
            tick();
        end
        CPU_WE_i = 1'b0;
        chk("rst_pre_busy", 32'(FILL_BUSY_o), 32'd1);
        SR_i = 1'b1;
        fill_q.delete();
        cpu_q.delete();
        ticks(2);
        SR_i = 1'b0;
        chk_outputs_zero("midrst");
        w0 = wr_cnt;
        ee_run = 1'b1;
        ticks(60);
        ee_run = 1'b0; CK_EE_i = 1'b0;
        chk("midrst_nowrite", 32'(wr_cnt - w0), 32'd0);
        chk("midrst_busy", 32'(FILL_BUSY_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish by 2 ms expected completion");
        $fatal(1, "watchdog");
    end
endmodule
